// File: rtl/dec3to8_pkg.sv
// Shared widths, constants and types for the registered 3-to-8 decoder.
package dec3to8_pkg;

  localparam int DEC_IN_W  = 3;
  localparam int DEC_OUT_W = 8;
  localparam logic [DEC_OUT_W-1:0] DEC_ZERO = 8'h00;

  typedef logic [DEC_IN_W-1:0]  dec_sel_t;
  typedef logic [DEC_OUT_W-1:0] dec_onehot_t;

endpackage

// File: rtl/dec3to8_core.sv
// Combinational 3-to-8 one-hot decode gated by en; USE_CASE picks shift (0) or case table (1).
module dec3to8_core
  import dec3to8_pkg::*;
#(
  parameter bit USE_CASE = 1'b0
) (
  input  logic                 en,
  input  logic [DEC_IN_W-1:0]  in,
  output logic [DEC_OUT_W-1:0] out
);

  generate
    if (USE_CASE) begin : g_case
      dec_onehot_t dec;

      // Unknown select values fall to the default arm, so X/Z decodes to zero.
      always_comb begin
        dec = DEC_ZERO;
        case (in)
          3'd0:    dec = 8'b0000_0001;
          3'd1:    dec = 8'b0000_0010;
          3'd2:    dec = 8'b0000_0100;
          3'd3:    dec = 8'b0000_1000;
          3'd4:    dec = 8'b0001_0000;
          3'd5:    dec = 8'b0010_0000;
          3'd6:    dec = 8'b0100_0000;
          3'd7:    dec = 8'b1000_0000;
          default: dec = DEC_ZERO;
        endcase
      end

      assign out = en ? dec : DEC_ZERO;
    end else begin : g_shift
      assign out = {{(DEC_OUT_W-1){1'b0}}, en} << in;
    end
  endgenerate

endmodule

// File: rtl/dec3to8.sv
// Registered 3-to-8 decoder built twice (shift and case) with a registered cross-check flag.
// Latency 1 cycle, one decode per cycle, no handshake.
module dec3to8
  import dec3to8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DEC_IN_W-1:0]  in,
  output logic [DEC_OUT_W-1:0] out_shift,
  output logic [DEC_OUT_W-1:0] out_case,
  output logic                 mismatch
);

  dec_onehot_t dec_shift;
  dec_onehot_t dec_case;
  logic        diff;

  dec3to8_core #(.USE_CASE(1'b0)) u_shift (
    .en  (en),
    .in  (in),
    .out (dec_shift)
  );

  dec3to8_core #(.USE_CASE(1'b1)) u_case (
    .en  (en),
    .in  (in),
    .out (dec_case)
  );

  assign diff = |(dec_shift ^ dec_case);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_shift <= DEC_ZERO;
      out_case  <= DEC_ZERO;
      mismatch  <= 1'b0;
    end else begin
      out_shift <= dec_shift;
      out_case  <= dec_case;
      mismatch  <= diff;
    end
  end

endmodule

// File: tb/tb_dec3to8.sv
// Directed bench for dec3to8: inputs driven on the falling edge, outputs checked one falling edge later.
module tb_dec3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] in;
  logic [7:0] out_shift;
  logic [7:0] out_case;
  logic       mismatch;

  int n_assert = 0;
  int n_fail   = 0;

  dec3to8 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in        (in),
    .out_shift (out_shift),
    .out_case  (out_case),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written as a bit loop, independent of the RTL forms.
  function automatic logic [7:0] ref_dec(input logic e, input logic [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < 8; b++)
      if (e && (s == b[2:0])) r[b] = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    n_assert++;
    assert (out_shift === exp) else begin
      n_fail++;
      $display("FAIL %s out_shift observed=%h expected=%h", tag, out_shift, exp);
      $error("%s out_shift observed=%h expected=%h", tag, out_shift, exp);
    end
    n_assert++;
    assert (out_case === exp) else begin
      n_fail++;
      $display("FAIL %s out_case observed=%h expected=%h", tag, out_case, exp);
      $error("%s out_case observed=%h expected=%h", tag, out_case, exp);
    end
    n_assert++;
    assert (mismatch === 1'b0) else begin
      n_fail++;
      $display("FAIL %s mismatch observed=%b expected=0", tag, mismatch);
      $error("%s mismatch observed=%b expected=0", tag, mismatch);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    in  = 3'b101;

    @(negedge clk);
    check("reset_c1", 8'h00);
    @(negedge clk);
    check("reset_c2", 8'h00);

    rst = 1'b0;
    en  = 1'b0;
    in  = 3'b000;
    @(negedge clk);
    check("disabled", 8'b0000_0000);

    en = 1'b1;
    in = 3'b000; @(negedge clk); check("dec_000", 8'b0000_0001);
    in = 3'b010; @(negedge clk); check("dec_010", 8'b0000_0100);
    in = 3'b100; @(negedge clk); check("dec_100", 8'b0001_0000);
    in = 3'b001; @(negedge clk); check("dec_001", 8'b0000_0010);
    in = 3'b111; @(negedge clk); check("dec_111", 8'b1000_0000);

    for (int k = 0; k < 16; k++) begin
      logic [3:0] v;
      v  = k[3:0];
      en = v[3];
      in = v[2:0];
      @(negedge clk);
      check($sformatf("exh_%0d", k), ref_dec(v[3], v[2:0]));
    end

    in = 3'b110;
    en = 1'b1; @(negedge clk); check("tog_en1a", 8'h40);
    en = 1'b0; @(negedge clk); check("tog_en0",  8'h00);
    en = 1'b1; @(negedge clk); check("tog_en1b", 8'h40);

    in = 3'b011;
    @(negedge clk); check("mid_pre",  8'h08);
    rst = 1'b1;
    @(negedge clk); check("mid_rst",  8'h00);
    rst = 1'b0;
    @(negedge clk); check("mid_post", 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
